round_seq_ctrl: RTL and testbench
=================================

ROUND_SEQ_CTRL -- requirements
Module: round_seq_ctrl

Interface
REQ-001 Parameter LAT, default 2, cycles from o_rnd_valid issue to matching i_rnd_dat from the round datapath.
REQ-002 Parameter FIFO_DEPTH, default 4, result FIFO depth in 256-bit entries; SHALL be >= LAT+2 and even.
REQ-003 i_clk  input  1  sole clock, all flops rising-edge.
REQ-004 i_rst_n  input  1  asynchronous active-low reset.
REQ-005 i_start  input  1  one-cycle pulse; latch config, begin tile.
REQ-006 i_q_encode / w_q_encode / o_q_encode  input  4 each  unsigned Q-format encodes.
REQ-007 i_round_mode  input  2  0 trunc, 1 nearest. i_shift_en  input  1.
REQ-008 i_num_vec  input  16  number of 512-bit bias vectors in the tile.
REQ-009 o_busy  output  1  high from IDLE exit until DONE. o_done  output  1  one-cycle completion pulse. o_cfg_err  output  1  sticky negative-shift flag.
REQ-010 s_valid  input  1, s_data  input  512, s_ready  output  1  bias input stream.
REQ-011 o_rnd_valid  output  1, o_rnd_dat  output  512, o_shift_num  output  5, o_round_mode  output  2, o_shift_en  output  1  drive to round datapath.
REQ-012 i_rnd_dat  input  256  32x8-bit rounded result from datapath.
REQ-013 m_valid  output  1, m_data  output  512, m_last  output  1, m_ready  input  1  packed output stream.

Function
REQ-014 FSM states IDLE, CFG, RUN, DRAIN, DONE; i_start ignored outside IDLE.
REQ-015 IDLE + i_start: latch all config inputs -> CFG; if i_num_vec==0 -> DONE directly.
REQ-016 CFG (1 cycle): sum = i_q+w_q-o_q computed 6-bit signed; sum<0 -> o_shift_num=0, set o_cfg_err; else o_shift_num=sum[4:0]; -> RUN. o_shift_num/o_round_mode/o_shift_en held constant until next CFG.
REQ-017 RUN: s_ready = (remaining>0) && (fifo_count + inflight) < FIFO_DEPTH; s_ready never depends combinationally on s_valid.
REQ-018 s_valid&&s_ready: o_rnd_dat<=s_data, o_rnd_valid<=1 next cycle, remaining decrements; o_rnd_valid low otherwise.
REQ-019 Inflight tracked by LAT-deep valid shift register; its output writes i_rnd_dat into FIFO; FIFO never overflows by construction (credit rule REQ-017).
REQ-020 remaining reaches 0 -> DRAIN; DRAIN with inflight==0 and FIFO empty and no pending m beat -> DONE.
REQ-021 DONE: o_done=1 one cycle, -> IDLE; o_cfg_err cleared on next i_start only.
REQ-022 m_valid when FIFO holds >=2 entries, or 1 entry that is the final vector of an odd-count tile; m_data={second entry, first entry} (first-accepted in bits 255:0); odd final beat upper half zero.
REQ-023 m_last=1 on the beat containing the final vector; m_valid/m_data/m_last stable while m_valid&&!m_ready.
REQ-024 m_valid&&m_ready pops 2 entries (1 on odd final beat); FIFO push and pop same cycle allowed, count updated net.
REQ-025 Full m_ready stall: input throttles to zero after FIFO_DEPTH-inflight accepts; no data lost or reordered.

Reset
REQ-026 i_rst_n low: state IDLE, counters/FIFO/valid pipe cleared; o_busy, o_done, o_cfg_err, s_ready, o_rnd_valid, m_valid, m_last =0; o_rnd_dat, m_data, o_shift_num, o_round_mode, o_shift_en =0.
REQ-027 Reset mid-tile aborts immediately; no o_done; in-flight results discarded; after release block accepts i_start in first cycle.

Verification
REQ-028 q=4,w=4,o=3, num_vec=4, m_ready=1, s_valid=1 -> o_shift_num=5, 2 m beats, m_last on 2nd, o_done 1 cycle after last beat drains, o_cfg_err=0.
REQ-029 num_vec=3 -> 2 beats; 2nd beat m_data[511:256]=0, m_last=1.
REQ-030 q=1,w=1,o=5 -> o_shift_num=0, o_cfg_err=1 held until next i_start.
REQ-031 m_ready=0 for 20 cycles, num_vec=8, LAT=2, DEPTH=4 -> exactly 4 vectors accepted then s_ready=0; release -> all 4 beats in order, data matches golden.
REQ-032 num_vec=0 -> o_done pulse 2 cycles after i_start, no s_ready, no m_valid.
REQ-033 Assert i_rst_n low while 2 results in flight -> all outputs 0 next edge; new tile afterwards completes correctly.

Source files
------------

// File: rtl/round_seq_ctrl_if.sv
// rtl/round_seq_ctrl_if.sv - bias input stream and packed output stream bundle
interface round_seq_ctrl_if;
    logic         s_valid;
    logic [511:0] s_data;
    logic         s_ready;
    logic         m_valid;
    logic [511:0] m_data;
    logic         m_last;
    logic         m_ready;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_last
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/round_seq_ctrl.sv
// rtl/round_seq_ctrl.sv - tile sequencer: feeds the round datapath, packs 256-bit results into 512-bit beats
module round_seq_ctrl #(
    parameter int LAT        = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_start,
    input  logic [3:0]     i_q_encode,
    input  logic [3:0]     w_q_encode,
    input  logic [3:0]     o_q_encode,
    input  logic [1:0]     i_round_mode,
    input  logic           i_shift_en,
    input  logic [15:0]    i_num_vec,
    output logic           o_busy,
    output logic           o_done,
    output logic           o_cfg_err,
    output logic           o_rnd_valid,
    output logic [511:0]   o_rnd_dat,
    output logic [4:0]     o_shift_num,
    output logic [1:0]     o_round_mode,
    output logic           o_shift_en,
    input  logic [255:0]   i_rnd_dat,
    round_seq_ctrl_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = $clog2(LAT + 2);

    typedef enum logic [2:0] {ST_IDLE, ST_CFG, ST_RUN, ST_DRAIN, ST_DONE} state_t;
    state_t state, state_nxt;

    logic [3:0]    q_i_r, q_w_r, q_o_r;
    logic [1:0]    mode_r;
    logic          shen_r;
    logic [15:0]   num_vec_r, remaining, popped;
    logic [LAT-1:0] vpipe;
    logic [IW-1:0] inflight;
    logic [255:0]  mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr1;
    logic [CW-1:0] count;
    logic          s_ready_c, accept, push, pop, pop_two, head_final, start_take;
    logic [5:0]    sum;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (int'(p) == FIFO_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    // Encodes are at most 15 each, so the 6-bit two's-complement result cannot overflow.
    assign sum        = {2'b00, q_i_r} + {2'b00, q_w_r} - {2'b00, q_o_r};
    assign start_take = (state == ST_IDLE) && i_start;
    assign accept     = s_ready_c && bus.s_valid;
    assign push       = vpipe[LAT-1];
    assign rd_ptr1    = ptr_inc(rd_ptr);
    assign head_final = (popped + 16'd1) == num_vec_r;
    assign pop_two    = count >= CW'(2);

    always_comb begin
        inflight = IW'(o_rnd_valid);
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + IW'(vpipe[i]);
        end
    end

    // A lone entry is only emitted when it is the odd tail of the tile.
    assign bus.m_valid = pop_two || ((count == CW'(1)) && num_vec_r[0] && head_final);
    assign bus.m_last  = bus.m_valid && (pop_two ? ((popped + 16'd2) == num_vec_r) : 1'b1);
    assign bus.m_data  = bus.m_valid ? {(pop_two ? mem[rd_ptr1] : 256'd0), mem[rd_ptr]} : '0;
    assign bus.s_ready = s_ready_c;
    assign pop         = bus.m_valid && bus.m_ready;
    assign o_busy      = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        s_ready_c = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start) state_nxt = (i_num_vec == 16'd0) ? ST_DONE : ST_CFG;
            end
            ST_CFG: state_nxt = ST_RUN;
            ST_RUN: begin
                // Credit covers both FIFO occupancy and results still in the datapath.
                s_ready_c = (remaining != 16'd0) && ((int'(count) + int'(inflight)) < FIFO_DEPTH);
                if (remaining == 16'd0) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if ((inflight == '0) && (count == '0)) state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_IDLE;
            q_i_r        <= '0;
            q_w_r        <= '0;
            q_o_r        <= '0;
            mode_r       <= '0;
            shen_r       <= 1'b0;
            num_vec_r    <= '0;
            o_shift_num  <= '0;
            o_round_mode <= '0;
            o_shift_en   <= 1'b0;
            o_cfg_err    <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            state  <= state_nxt;
            o_done <= (state == ST_DONE);
            if (start_take) begin
                q_i_r     <= i_q_encode;
                q_w_r     <= w_q_encode;
                q_o_r     <= o_q_encode;
                mode_r    <= i_round_mode;
                shen_r    <= i_shift_en;
                num_vec_r <= i_num_vec;
                o_cfg_err <= 1'b0;
            end
            if (state == ST_CFG) begin
                o_shift_num  <= sum[5] ? 5'd0 : sum[4:0];
                o_round_mode <= mode_r;
                o_shift_en   <= shen_r;
                if (sum[5]) o_cfg_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rnd_valid <= 1'b0;
            o_rnd_dat   <= '0;
            vpipe       <= '0;
            remaining   <= '0;
            popped      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            o_rnd_valid <= accept;
            if (accept) o_rnd_dat <= bus.s_data;
            vpipe[0] <= o_rnd_valid;
            for (int i = 1; i < LAT; i++) vpipe[i] <= vpipe[i-1];
            if (start_take) begin
                remaining <= i_num_vec;
                popped    <= '0;
            end else if (accept) begin
                remaining <= remaining - 16'd1;
            end
            if (push) begin
                mem[wr_ptr] <= i_rnd_dat;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= pop_two ? ptr_inc(rd_ptr1) : rd_ptr1;
                popped <= popped + (pop_two ? 16'd2 : 16'd1);
            end
            count <= count + CW'(push) - (pop ? (pop_two ? CW'(2) : CW'(1)) : CW'(0));
        end
    end
endmodule

// File: tb/tb_round_seq_ctrl.sv
// tb/tb_round_seq_ctrl.sv - directed self-checking bench for round_seq_ctrl
module tb_round_seq_ctrl;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_start = 1'b0;
    logic [3:0]   i_q_encode = '0, w_q_encode = '0, o_q_encode = '0;
    logic [1:0]   i_round_mode = '0;
    logic         i_shift_en = 1'b0;
    logic [15:0]  i_num_vec = '0;
    logic         o_busy, o_done, o_cfg_err, o_rnd_valid, o_shift_en;
    logic [511:0] o_rnd_dat;
    logic [4:0]   o_shift_num;
    logic [1:0]   o_round_mode;
    logic [255:0] i_rnd_dat;
    logic [255:0] dp0 = '0, dp1 = '0;

    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    round_seq_ctrl_if bus ();

    round_seq_ctrl #(.LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_q_encode   (i_q_encode),
        .w_q_encode   (w_q_encode),
        .o_q_encode   (o_q_encode),
        .i_round_mode (i_round_mode),
        .i_shift_en   (i_shift_en),
        .i_num_vec    (i_num_vec),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_cfg_err    (o_cfg_err),
        .o_rnd_valid  (o_rnd_valid),
        .o_rnd_dat    (o_rnd_dat),
        .o_shift_num  (o_shift_num),
        .o_round_mode (o_round_mode),
        .o_shift_en   (o_shift_en),
        .i_rnd_dat    (i_rnd_dat),
        .bus          (bus)
    );

    function automatic logic [255:0] rnd_f(input logic [511:0] x);
        return x[255:0] + x[511:256];
    endfunction

    function automatic logic [511:0] mkvec(input int tile, input int idx);
        logic [511:0] v;
        for (int k = 0; k < 16; k++) v[k*32 +: 32] = {8'(tile), 8'(idx), 8'(k), 8'h5a};
        return v;
    endfunction

    // Round datapath model: result appears LAT cycles after o_rnd_valid.
    always @(posedge i_clk) begin
        dp0 <= rnd_f(o_rnd_dat);
        dp1 <= dp0;
    end
    assign i_rnd_dat = dp1;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_tile(input int num, input int qi, input int qw, input int qo, input int stall,
                            input int rst_at, input int tile, input logic [4:0] exp_sh, input logic exp_err);
        int acc = 0, beats = 0, cyc = 0, done_cnt = 0, done_cyc = 0;
        int nbeats = (num + 1) / 2;
        logic sv_hs, mv_hs, prev_stall;
        logic [511:0] exp_d, prev_md;
        prev_stall = 1'b0;
        prev_md    = '0;
        @(posedge i_clk); #1;
        i_q_encode = 4'(qi); w_q_encode = 4'(qw); o_q_encode = 4'(qo);
        i_round_mode = 2'd1; i_shift_en = 1'b1; i_num_vec = 16'(num); i_start = 1'b1;
        bus.s_valid = 1'b0; bus.m_ready = (stall == 0);
        @(posedge i_clk); #1;
        i_start = 1'b0; i_q_encode = 4'hf; w_q_encode = 4'hf; o_q_encode = 4'h0;
        i_round_mode = 2'd2; i_shift_en = 1'b0; i_num_vec = 16'd0;
        bus.s_valid = (num > 0); bus.s_data = mkvec(tile, 0);
        while (cyc < 400) begin
            @(negedge i_clk);
            if (rst_at > 0 && acc == rst_at) begin
                i_rst_n = 1'b0;
                #1;
                chk("abort_ctrl", {o_busy, o_done, o_cfg_err, bus.s_ready, o_rnd_valid, bus.m_valid, bus.m_last}, 0);
                chk("abort_data", o_rnd_dat | bus.m_data, 0);
                chk("abort_cfg", {o_shift_num, o_round_mode, o_shift_en}, 0);
                bus.s_valid = 1'b0;
                @(posedge i_clk); #1;
                chk("abort_hold", {o_busy, o_done, o_rnd_valid, bus.m_valid, o_shift_num}, 0);
                @(negedge i_clk);
                i_rst_n = 1'b1;
                return;
            end
            if (done_cnt > 0) begin
                chk("done_width", o_done, 0);
                break;
            end
            if (cyc == 1) begin
                chk("shift_num", o_shift_num, exp_sh);
                chk("cfg_err", o_cfg_err, exp_err);
                chk("round_mode", o_round_mode, 2'd1);
                chk("shift_en", o_shift_en, 1'b1);
                chk("busy", o_busy, 1'b1);
            end
            if (prev_stall) chk("m_stable", bus.m_data, prev_md);
            sv_hs = bus.s_valid && bus.s_ready;
            mv_hs = bus.m_valid && bus.m_ready;
            if (stall > 0 && cyc == stall) begin
                chk("stall_acc", acc + int'(sv_hs), DEPTH);
                chk("stall_rdy", bus.s_ready, 0);
            end
            if (mv_hs) begin
                exp_d[255:0]   = rnd_f(mkvec(tile, 2 * beats));
                exp_d[511:256] = (2 * beats + 1 < num) ? rnd_f(mkvec(tile, 2 * beats + 1)) : 256'd0;
                chk("m_data", bus.m_data, exp_d);
                chk("m_last", bus.m_last, beats == nbeats - 1);
                beats++;
            end
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_after_beats", beats, nbeats);
                chk("done_busy", o_busy, 0);
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_md    = bus.m_data;
            @(posedge i_clk); #1;
            if (sv_hs) begin
                acc++;
                bus.s_data  = mkvec(tile, acc);
                bus.s_valid = (acc < num);
            end
            bus.m_ready = (cyc + 1 >= stall);
            cyc++;
        end
        chk("done_cnt", done_cnt, 1);
        chk("beats", beats, nbeats);
        chk("accepts", acc, num);
        chk("err_hold", o_cfg_err, exp_err);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_ctrl", {o_busy, o_done, o_cfg_err, bus.s_ready, o_rnd_valid, bus.m_valid, bus.m_last}, 0);
        chk("rst_data", o_rnd_dat | bus.m_data, 0);
        chk("rst_cfg", {o_shift_num, o_round_mode, o_shift_en}, 0);
        i_rst_n = 1'b1;

        run_tile(4, 4, 4, 3, 0, 0, 1, 5'd5, 1'b0);
        run_tile(3, 4, 4, 3, 0, 0, 2, 5'd5, 1'b0);
        run_tile(2, 1, 1, 5, 0, 0, 3, 5'd0, 1'b1);
        repeat (5) @(posedge i_clk);
        @(negedge i_clk);
        chk("err_sticky", o_cfg_err, 1);
        run_tile(8, 2, 3, 1, 20, 0, 4, 5'd4, 1'b0);

        @(posedge i_clk); #1;
        i_num_vec = 16'd0; i_start = 1'b1; bus.m_ready = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        @(negedge i_clk);
        chk("zero_done_c1", o_done, 0);
        chk("zero_sready", bus.s_ready, 0);
        @(negedge i_clk);
        chk("zero_done_c2", o_done, 1);
        chk("zero_mvalid", bus.m_valid, 0);
        @(negedge i_clk);
        chk("zero_done_c3", o_done, 0);

        run_tile(8, 4, 4, 3, 0, 2, 5, 5'd5, 1'b0);
        run_tile(5, 4, 4, 3, 0, 0, 6, 5'd5, 1'b0);
        run_tile(1, 15, 15, 0, 0, 0, 7, 5'd30, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
